// File: rtl/axi_mm_mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: port count and FSM encoding.
package axi_mm_mem_arb_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/axi_mm_mem_rr_pick2.sv
// Two-way round-robin winner selection; a lone requester always wins,
// on contention the port not granted last wins.
module axi_mm_mem_rr_pick2
   import axi_mm_mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last_grant,
   output logic               valid,
   output logic               winner
);

   // Winner decode from the request vector and previous grant
   always_comb begin
      valid  = |req;
      winner = 1'b0;
      case (req)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_grant;
         default: winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/axi_mm_mem_arbiter.sv
// Arbitrates two request ports onto one single-port byte-strobed memory
// with a registered 1-cycle read; all outputs are driven from flops.
module axi_mm_mem_arbiter
   import axi_mm_mem_arb_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int OPT_MEM_ADDR_BITS  = 0
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic [NUM_REQ-1:0]                                  req_i,
   input  logic [NUM_REQ-1:0]                                  we_i,
   input  logic [NUM_REQ-1:0][C_S_AXI_DATA_WIDTH/8-1:0]        wstrb_i,
   input  logic [NUM_REQ-1:0][OPT_MEM_ADDR_BITS:0]             addr_i,
   input  logic [NUM_REQ-1:0][C_S_AXI_DATA_WIDTH-1:0]          wdata_i,
   output logic [NUM_REQ-1:0]                                  ack_o,
   output logic [NUM_REQ-1:0]                                  rvalid_o,
   output logic [NUM_REQ-1:0][C_S_AXI_DATA_WIDTH-1:0]          rdata_o,
   output logic                                                mem_wen,
   output logic                                                mem_ren,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0]                     mem_wstrb,
   output logic [OPT_MEM_ADDR_BITS:0]                          mem_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0]                       mem_wdata,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]                       mem_rdata
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int SW = C_S_AXI_DATA_WIDTH / 8;
   localparam int AW = OPT_MEM_ADDR_BITS + 1;

   arb_state_e                     state_r;
   logic                           last_grant_r;
   logic                           winner_r;
   logic                           op_write_r;
   logic [NUM_REQ-1:0]             ack_r;
   logic [NUM_REQ-1:0]             rvalid_r;
   logic [NUM_REQ-1:0][DW-1:0]     rdata_r;
   logic                           mem_wen_r;
   logic                           mem_ren_r;
   logic [SW-1:0]                  mem_wstrb_r;
   logic [AW-1:0]                  mem_addr_r;
   logic [DW-1:0]                  mem_wdata_r;

   logic                           pick_valid_s;
   logic                           pick_winner_s;

   axi_mm_mem_rr_pick2 u_pick (
      .req        (req_i),
      .last_grant (last_grant_r),
      .valid      (pick_valid_s),
      .winner     (pick_winner_s)
   );

   // Arbitration FSM; enables, ack and rvalid are single-cycle pulses that
   // default low, while memory fields and read data hold between accesses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
         winner_r     <= 1'b0;
         op_write_r   <= 1'b0;
         ack_r        <= '0;
         rvalid_r     <= '0;
         rdata_r      <= '0;
         mem_wen_r    <= 1'b0;
         mem_ren_r    <= 1'b0;
         mem_wstrb_r  <= '0;
         mem_addr_r   <= '0;
         mem_wdata_r  <= '0;
      end else begin
         ack_r     <= '0;
         rvalid_r  <= '0;
         mem_wen_r <= 1'b0;
         mem_ren_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pick_valid_s) begin
                  winner_r               <= pick_winner_s;
                  last_grant_r           <= pick_winner_s;
                  op_write_r             <= we_i[pick_winner_s];
                  mem_wen_r              <= we_i[pick_winner_s];
                  mem_ren_r              <= ~we_i[pick_winner_s];
                  mem_wstrb_r            <= wstrb_i[pick_winner_s];
                  mem_addr_r             <= addr_i[pick_winner_s];
                  mem_wdata_r            <= wdata_i[pick_winner_s];
                  ack_r[pick_winner_s]   <= 1'b1;
                  state_r                <= ST_ACCESS;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               if (op_write_r) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Memory output is valid this cycle, one after the read enable
               rdata_r[winner_r]  <= mem_rdata;
               rvalid_r[winner_r] <= 1'b1;
               state_r            <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack_o     = ack_r;
   assign rvalid_o  = rvalid_r;
   assign rdata_o   = rdata_r;
   assign mem_wen   = mem_wen_r;
   assign mem_ren   = mem_ren_r;
   assign mem_wstrb = mem_wstrb_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_axi_mm_mem_arbiter.sv
// Directed bench for the two-port memory arbiter with a behavioural
// byte-strobed memory having a registered 1-cycle read.
module tb_axi_mm_mem_arbiter;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [1:0]            req;
   logic [1:0]            we;
   logic [1:0][3:0]       wstrb;
   logic [1:0][0:0]       addr;
   logic [1:0][31:0]      wdata;
   logic [1:0]            ack_o;
   logic [1:0]            rvalid_o;
   logic [1:0][31:0]      rdata_o;
   logic                  mem_wen;
   logic                  mem_ren;
   logic [3:0]            mem_wstrb;
   logic [0:0]            mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   logic [31:0]           mem_model [2];
   int                    checks = 0;
   int                    errors = 0;

   always #5 clk = ~clk;

   axi_mm_mem_arbiter #(
      .C_S_AXI_DATA_WIDTH (32),
      .OPT_MEM_ADDR_BITS  (0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .we_i      (we),
      .wstrb_i   (wstrb),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .ack_o     (ack_o),
      .rvalid_o  (rvalid_o),
      .rdata_o   (rdata_o),
      .mem_wen   (mem_wen),
      .mem_ren   (mem_ren),
      .mem_wstrb (mem_wstrb),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Behavioural memory: strobed write, registered read
   always @(posedge clk) begin
      if (mem_wen) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      if (mem_ren) mem_rdata <= mem_model[mem_addr];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Write and read enables must never overlap
   always @(negedge clk) begin
      if (rst_n) check_val("wen_ren_excl", {31'd0, mem_wen & mem_ren}, 32'd0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction from an idle arbiter; port drops req once acked
   task automatic do_txn(input int p, input logic w, input logic [0:0] a,
                         input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] exp_rd);
      logic [1:0] onehot;
      onehot   = 2'b01 << p;
      req[p]   = 1'b1;
      we[p]    = w;
      addr[p]  = a;
      wdata[p] = wd;
      wstrb[p] = ws;
      step();
      check_val("txn_ack", {30'd0, ack_o}, {30'd0, onehot});
      check_val("txn_wen", {31'd0, mem_wen}, {31'd0, w});
      check_val("txn_ren", {31'd0, mem_ren}, {31'd0, ~w});
      check_val("txn_addr", {31'd0, mem_addr}, {31'd0, a});
      req[p] = 1'b0;
      step();
      check_val("txn_ack_done", {30'd0, ack_o}, 32'd0);
      check_val("txn_en_idle", {30'd0, mem_wen, mem_ren}, 32'd0);
      if (!w) begin
         check_val("txn_rvalid_early", {30'd0, rvalid_o}, 32'd0);
         step();
         check_val("txn_rvalid", {30'd0, rvalid_o}, {30'd0, onehot});
         check_val("txn_rdata", rdata_o[p], exp_rd);
      end
   endtask

   initial begin
      mem_model[0] = 32'd0;
      mem_model[1] = 32'd0;
      mem_rdata    = 32'd0;
      rst_n = 1'b0;
      req   = 2'b00;
      we    = 2'b00;
      wstrb = '0;
      addr  = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ack", {30'd0, ack_o}, 32'd0);
      check_val("rst_rvalid", {30'd0, rvalid_o}, 32'd0);
      check_val("rst_en", {30'd0, mem_wen, mem_ren}, 32'd0);
      check_val("rst_rdata1", rdata_o[1], 32'd0);
      #2 rst_n = 1'b1;

      // Write then cross-port read, with latency checks
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 1'b0; wdata[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
      step();
      check_val("w_ack_t1", {30'd0, ack_o}, 32'd1);
      check_val("w_wen_t1", {31'd0, mem_wen}, 32'd1);
      check_val("w_wdata_t1", mem_wdata, 32'hDEADBEEF);
      req[0] = 1'b0;
      step();
      check_val("w_ack_t2", {30'd0, ack_o}, 32'd0);
      check_val("w_wdata_hold", mem_wdata, 32'hDEADBEEF);
      check_val("w_wstrb_hold", {28'd0, mem_wstrb}, 32'hF);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 1'b0;
      step();
      check_val("r_ack_t1", {30'd0, ack_o}, 32'd2);
      check_val("r_ren_t1", {31'd0, mem_ren}, 32'd1);
      req[1] = 1'b0;
      step();
      check_val("r_rvalid_t2", {30'd0, rvalid_o}, 32'd0);
      check_val("r_ren_t2", {31'd0, mem_ren}, 32'd0);
      step();
      check_val("r_rvalid_t3", {30'd0, rvalid_o}, 32'd2);
      check_val("r_rdata_t3", rdata_o[1], 32'hDEADBEEF);
      step();
      check_val("r_rvalid_t4", {30'd0, rvalid_o}, 32'd0);
      check_val("r_rdata_hold", rdata_o[1], 32'hDEADBEEF);

      // Both ports hold reads: grants alternate starting from port 0
      req = 2'b11; we = 2'b00; addr[0] = 1'b0; addr[1] = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         check_val("alt_grant", {30'd0, ack_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
         step();
         step();
         if (i == 5) req = 2'b00;
         step();
      end

      // Partial-strobe merge
      do_txn(0, 1'b1, 1'b1, 32'h11223344, 4'hF, 32'd0);
      do_txn(0, 1'b1, 1'b1, 32'hAABBCCDD, 4'h3, 32'd0);
      do_txn(0, 1'b0, 1'b1, 32'd0, 4'h0, 32'h1122CCDD);

      // Zero-strobe write still acks and leaves data intact
      do_txn(1, 1'b1, 1'b0, 32'h00000005, 4'hF, 32'd0);
      do_txn(1, 1'b1, 1'b0, 32'hFFFFFFFF, 4'h0, 32'd0);
      do_txn(0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h00000005);

      // Port 1 alone streams 4 writes, one every 2 cycles
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 1'b1; wstrb[1] = 4'hF; wdata[1] = 32'h100;
      step();
      for (int i = 0; i < 4; i++) begin
         check_val("stream_ack", {30'd0, ack_o}, 32'd2);
         check_val("stream_wdata", mem_wdata, 32'h100 + i);
         wdata[1] = 32'h101 + i;
         if (i == 3) req[1] = 1'b0;
         step();
         check_val("stream_gap", {30'd0, ack_o}, 32'd0);
         step();
      end

      // Asynchronous reset in RESP drops the read and restores grant order
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 1'b1;
      step();
      check_val("rr_ack", {30'd0, ack_o}, 32'd1);
      req[0] = 1'b0;
      step();
      #1 rst_n = 1'b0;
      #1;
      check_val("arst_ack", {30'd0, ack_o}, 32'd0);
      check_val("arst_rvalid", {30'd0, rvalid_o}, 32'd0);
      check_val("arst_rdata0", rdata_o[0], 32'd0);
      check_val("arst_rdata1", rdata_o[1], 32'd0);
      check_val("arst_en", {30'd0, mem_wen, mem_ren}, 32'd0);
      check_val("arst_addr", {31'd0, mem_addr}, 32'd0);
      check_val("arst_wdata", mem_wdata, 32'd0);
      check_val("arst_wstrb", {28'd0, mem_wstrb}, 32'd0);
      #1 rst_n = 1'b1;
      step();
      check_val("arst_no_rvalid_a", {30'd0, rvalid_o}, 32'd0);
      step();
      check_val("arst_no_rvalid_b", {30'd0, rvalid_o}, 32'd0);
      req = 2'b11; we = 2'b00; addr[0] = 1'b0; addr[1] = 1'b0;
      step();
      check_val("arst_first_grant", {30'd0, ack_o}, 32'd1);
      req = 2'b00;
      repeat (3) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_mm_mem_arbiter.md
AXI_MM_MEM_ARBITER -- requirements
Module: axi_mm_mem_arbiter

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, SHALL set the data width; a multiple of 8.
REQ-002 Parameter OPT_MEM_ADDR_BITS, default 0, SHALL set the address width to OPT_MEM_ADDR_BITS+1.
REQ-003 clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_i[i], i=0..1  in  1  SHALL be a transaction request, held high with fields stable until ack_o[i].
REQ-006 we_i[i]  in  1  SHALL select the operation: 1=write, 0=read.
REQ-007 wstrb_i[i]  in  DW/8  SHALL be the byte strobes for writes.
REQ-008 addr_i[i]  in  AW  SHALL be the word address.
REQ-009 wdata_i[i]  in  DW  SHALL be the write data.
REQ-010 ack_o[i]  out  1  SHALL pulse for one cycle when port i's access reaches the memory.
REQ-011 rvalid_o[i]  out  1  SHALL pulse for one cycle when rdata_o[i] carries new read data.
REQ-012 rdata_o[i]  out  DW  SHALL be port i's read data, held until its next read completes.
REQ-013 mem_wen, mem_ren  out  1  SHALL drive the memory write and read enables.
REQ-014 mem_wstrb/mem_addr/mem_wdata  out  DW/8 / AW / DW  SHALL drive the memory strobes, address and write data.
REQ-015 mem_rdata  in  DW  SHALL be the memory read data, valid the cycle after mem_ren.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-017 IDLE with any req_i high SHALL select a winner, register its fields onto mem_*, set mem_wen=we or mem_ren=~we, and go to ACCESS.
REQ-018 ACCESS SHALL last exactly one cycle with the mem enable and ack_o[winner] high, then go to IDLE (write) or RESP (read).
REQ-019 RESP SHALL capture mem_rdata into rdata_o[winner], set rvalid_o[winner] for the next cycle and return to IDLE.
REQ-020 Latency: req seen in IDLE at cycle T -> ack at T+1; for reads, rvalid at T+3.
REQ-021 Throughput: one write per 2 cycles; one read per 3 cycles.
REQ-022 A single requester SHALL always win.
REQ-023 With both requesting, the port not granted last SHALL win; last_grant SHALL update on every grant.
REQ-024 mem_wen and mem_ren SHALL never be high together and SHALL be low outside ACCESS.
REQ-025 mem_addr/mem_wdata/mem_wstrb SHALL hold their last values outside ACCESS.
REQ-026 A write with wstrb=0 SHALL still perform a full ACCESS cycle and ack.
REQ-027 req held high after ack SHALL be treated as a new transaction on the next IDLE cycle.
REQ-028 req dropped before ack SHALL be ignored unless already latched in the IDLE->ACCESS transition.

Reset
REQ-029 Asserting rst_n low SHALL, at any time, force state=IDLE and last_grant=1 (port 0 wins first).
REQ-030 Reset SHALL also force ack_o, rvalid_o, rdata_o, mem_wen, mem_ren, mem_wstrb, mem_addr and mem_wdata to 0.
REQ-031 A read pending at reset SHALL be dropped with no rvalid.

Structure
REQ-032 State encodings (IDLE=0, ACCESS=1, RESP=2) and NUM_REQ=2 SHALL live in the shared package axi_mm_mem_arb_pkg.
REQ-033 Winner selection SHALL be the combinational sub-module axi_mm_mem_rr_pick2 (inputs req[1:0], last_grant; outputs valid, winner).
REQ-034 The memory port SHALL connect directly to the team's single-port byte-strobed memory wrapper, which has a 1-cycle registered read.

Verification
REQ-035 Port 0 writes addr=0, wdata=0xDEADBEEF, wstrb=0xF; port 1 then reads addr=0 -> rvalid_o[1] with rdata_o[1]=0xDEADBEEF, at T+3 of the read.
REQ-036 Both ports hold read requests for 6 transactions -> grants alternate 0,1,0,1,0,1; no mem_wen/mem_ren overlap.
REQ-037 Write 0x11223344, then write 0xAABBCCDD with wstrb=0x3, then read -> 0x1122CCDD.
REQ-038 rst_n driven low asynchronously during RESP -> all outputs 0 immediately; no rvalid; next single request is granted port 0.
REQ-039 Port 1 alone holds req for 4 writes -> ack every 2nd cycle, with port 1 granted every time.
REQ-040 Write with wstrb=0 to an address holding 0x5 -> ack issued; a subsequent read returns 0x5.
